scalar_alu: RTL and testbench
=============================

# scalar_alu

Registered N-bit scalar ALU for the processor's scalar datapath. It computes one of eight operations on operands A and B. The result and five status flags are registered on the next rising clock edge and feed the writeback and branch-condition logic.

## Interface
Parameters:
- N, default 24: operand and result width (N ≥ 8).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
- A, input, N: operand A (unsigned or two's complement, depending on op).
- B, input, N: operand B; shift amount for shift ops.
- ALUControl, input, 3: operation select.
- Output, output, N: registered result.
- c_flag, output, 1: carry / no-borrow / multiply-overflow.
- z_flag, output, 1: Output == 0.
- gt_flag, output, 1: A > B, unsigned.
- v_flag, output, 1: signed overflow.
- n_flag, output, 1: Output[N-1].

## Operation
ALUControl encoding:
- 000 add: A + B, truncated to N bits.
- 001 sub: A − B, truncated to N bits.
- 010 sll: A << B. Result is 0 when B ≥ N.
- 011 mult: low N bits of the unsigned product A × B.
- 100 and: A & B.
- 101 or: A | B.
- 110 xor: A ^ B.
- 111 srl: A >> B, logical. Result is 0 when B ≥ N.

Flags, computed from the same cycle's inputs and the combinational result:
- c_flag:
  - add: carry out of bit N-1.
  - sub: 1 when A ≥ B unsigned (no borrow).
  - mult: 1 when the upper N bits of the 2N-bit product are nonzero.
  - all other ops: 0.
- v_flag:
  - add: A and B have the same sign and the result sign differs.
  - sub: A and B have different signs and the result sign differs from A.
  - all other ops: 0.
- z_flag, n_flag: derived from the N-bit result for every op.
- gt_flag: (A > B) unsigned, valid for every op.

## Timing
- Combinational result and flags are captured in output registers on each rising clk edge; latency is exactly 1 cycle.
- No enable or handshake: the registers load every cycle.
- Reset, while rst_n is low at a rising edge:
  - Output and c/gt/v/n flags = 0.
  - z_flag = 0. Reset value is forced, not derived from Output.
- Reset has priority over the operands. Asserting rst_n low mid-stream discards the in-flight result.
- First valid result appears 1 cycle after the first edge with rst_n high.
- Inputs changing between edges have no effect until the next edge.

## Configuration
- ALU_MULT_EN defined: op 011 uses the N×N multiplier as specified above.
- ALU_MULT_EN not defined:
  - No multiplier is synthesized.
  - Op 011 registers Output = 0, z_flag = 1, and c, v, n flags = 0.
  - gt_flag is still computed.

## Test plan
- add, N=24, A=130, B=229 → next cycle: Output=359 (0x000167); c=0, v=0, z=0, n=0, gt=0.
- sub, A=229, B=130 → Output=99 (0x000063), c=1, gt=1. Then sub A=0, B=1 → Output=0xFFFFFF, c=0, n=1, v=0.
- sll, A=5, B=2 → Output=20 (0x000014). Then A=5, B=24 → Output=0, z=1.
- mult (ALU_MULT_EN defined), A=10, B=5 → Output=50 (0x000032), c=0. Then A=0x001000, B=0x001000 → Output=0, c=1, z=1.
- add overflow, A=0x7FFFFF, B=1 → Output=0x800000, v=1, n=1, c=0. Then A=0xFFFFFF, B=1 → Output=0, c=1, z=1.
- Reset: drive any op with rst_n=0 for 2 edges → all outputs 0. Release rst_n → result of the current inputs appears on the following edge.

Source files
------------

// File: rtl/scalar_alu.sv
// scalar_alu: registered N-bit scalar ALU (add/sub/sll/mult/and/or/xor/srl).
// The result and the c/z/gt/v/n flags are captured one cycle after the inputs.
// Optional feature macro: ALU_MULT_EN enables the NxN multiplier on op 011.
// Without it, op 011 yields a zero result with z set.
module scalar_alu #(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   ALUControl,
  output logic [N-1:0] Output,
  output logic         c_flag,
  output logic         z_flag,
  output logic         gt_flag,
  output logic         v_flag,
  output logic         n_flag
);

  localparam int SHW = $clog2(N);
  // Shift amounts at or above this value flush the result to zero.
  localparam logic [SHW:0] NLIM = (SHW+1)'(N);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_SLL  = 3'b010,
    OP_MULT = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_SRL  = 3'b111
  } op_e;

  typedef struct packed {
    logic [N-1:0] res;
    logic         c;
    logic         z;
    logic         gt;
    logic         v;
    logic         n;
  } alu_out_t;

  alu_out_t     alu_d, alu_q;
  logic [N:0]   add_w, sub_w;
  logic         shift_oob;
  logic [SHW-1:0] shamt;

  // Extra top bit carries the add carry-out / sub borrow.
  assign add_w     = {1'b0, A} + {1'b0, B};
  assign sub_w     = {1'b0, A} - {1'b0, B};
  assign shamt     = B[SHW-1:0];
  assign shift_oob = (|B[N-1:SHW]) || ({1'b0, shamt} >= NLIM);

`ifdef ALU_MULT_EN
  logic [2*N-1:0] prod;
  assign prod = {{N{1'b0}}, A} * {{N{1'b0}}, B};
`endif

  // Next-state result and flags from the current operands.
  always_comb begin
    alu_d    = '0;
    alu_d.gt = (A > B);
    unique case (op_e'(ALUControl))
      OP_ADD: begin
        alu_d.res = add_w[N-1:0];
        alu_d.c   = add_w[N];
        alu_d.v   = (A[N-1] == B[N-1]) && (add_w[N-1] != A[N-1]);
      end
      OP_SUB: begin
        alu_d.res = sub_w[N-1:0];
        alu_d.c   = ~sub_w[N];
        alu_d.v   = (A[N-1] != B[N-1]) && (sub_w[N-1] != A[N-1]);
      end
      OP_SLL:  alu_d.res = shift_oob ? '0 : (A << shamt);
`ifdef ALU_MULT_EN
      OP_MULT: begin
        alu_d.res = prod[N-1:0];
        alu_d.c   = |prod[2*N-1:N];
      end
`else
      OP_MULT: alu_d.res = '0;
`endif
      OP_AND:  alu_d.res = A & B;
      OP_OR:   alu_d.res = A | B;
      OP_XOR:  alu_d.res = A ^ B;
      OP_SRL:  alu_d.res = shift_oob ? '0 : (A >> shamt);
      default: alu_d.res = '0;
    endcase
    alu_d.z = (alu_d.res == '0);
    alu_d.n = alu_d.res[N-1];
  end

  // Output register; reset forces every field, including z, to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) alu_q <= '0;
    else        alu_q <= alu_d;
  end

  assign Output  = alu_q.res;
  assign c_flag  = alu_q.c;
  assign z_flag  = alu_q.z;
  assign gt_flag = alu_q.gt;
  assign v_flag  = alu_q.v;
  assign n_flag  = alu_q.n;

endmodule

// File: tb/tb_scalar_alu.sv
// Directed + random bench for scalar_alu; expected results come from a
// 64-bit arithmetic reference model through a scoreboard queue.
module tb_scalar_alu;
  localparam int N = 24;
  localparam logic [63:0] MASK = (64'd1 << N) - 64'd1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] A, B;
  logic [2:0]   ALUControl;
  logic [N-1:0] Output;
  logic         c_flag, z_flag, gt_flag, v_flag, n_flag;

  int checks = 0;
  int errors = 0;
  logic [N+4:0] sb_q[$];

  scalar_alu #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .ALUControl(ALUControl),
    .Output(Output), .c_flag(c_flag), .z_flag(z_flag), .gt_flag(gt_flag),
    .v_flag(v_flag), .n_flag(n_flag)
  );

  always #5 clk = ~clk;

  // Packed order: {res, c, z, gt, v, n}
  function automatic logic [N+4:0] model(input logic [2:0] op,
                                         input logic [N-1:0] a,
                                         input logic [N-1:0] b,
                                         input logic rst);
    logic [63:0] ua, ub, t;
    logic [N-1:0] r;
    logic c, v;
    ua = 64'(a); ub = 64'(b); c = 1'b0; v = 1'b0; r = '0;
    if (!rst) return '0;
    case (op)
      3'd0: begin t = ua + ub; r = N'(t & MASK); c = t[N];
                  v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]); end
      3'd1: begin t = ua - ub; r = N'(t & MASK); c = (ua >= ub);
                  v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]); end
      3'd2: r = (ub >= 64'(N)) ? '0 : N'((ua << ub) & MASK);
`ifdef ALU_MULT_EN
      3'd3: begin t = ua * ub; r = N'(t & MASK); c = ((t >> N) != 64'd0); end
`else
      3'd3: r = '0;
`endif
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = (ub >= 64'(N)) ? '0 : N'(ua >> ub);
    endcase
    return {r, c, (r == '0), (ua > ub), v, r[N-1]};
  endfunction

  function automatic logic [N+4:0] dut_vec();
    return {Output, c_flag, z_flag, gt_flag, v_flag, n_flag};
  endfunction

  // Drive one set of inputs, push the expectation, compare after the edge.
  task automatic step(input string tag, input logic rst, input logic [2:0] op,
                      input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N+4:0] exp;
    @(negedge clk);
    rst_n = rst; ALUControl = op; A = a; B = b;
    sb_q.push_back(model(op, a, b, rst));
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    checks++;
    assert (dut_vec() === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, dut_vec(), exp);
    end
  endtask

  // Compare the registered outputs against a hand-derived constant.
  task automatic chk(input string tag, input logic [N-1:0] r, input logic c,
                     input logic z, input logic gt, input logic v, input logic n);
    logic [N+4:0] exp;
    exp = {r, c, z, gt, v, n};
    checks++;
    assert (dut_vec() === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, dut_vec(), exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; A = '0; B = '0; ALUControl = 3'd0;
    // Reset with live operands for two edges.
    step("rst0", 1'b0, 3'd0, 24'h7FFFFF, 24'd1);
    step("rst1", 1'b0, 3'd1, 24'd0, 24'd1);
    chk("rst_const", '0, 0, 0, 0, 0, 0);
    // Release: current inputs appear on the following edge.
    step("add_130_229", 1'b1, 3'd0, 24'd130, 24'd229);
    chk("add_const", 24'h000167, 0, 0, 0, 0, 0);
    step("sub_229_130", 1'b1, 3'd1, 24'd229, 24'd130);
    chk("sub_const", 24'h000063, 1, 0, 1, 0, 0);
    step("sub_0_1", 1'b1, 3'd1, 24'd0, 24'd1);
    chk("sub_borrow_const", 24'hFFFFFF, 0, 0, 0, 0, 1);
    step("sll_5_2", 1'b1, 3'd2, 24'd5, 24'd2);
    chk("sll_const", 24'h000014, 0, 0, 1, 0, 0);
    step("sll_5_24", 1'b1, 3'd2, 24'd5, 24'd24);
    chk("sll_oob_const", '0, 0, 1, 0, 0, 0);
    step("sll_1_23", 1'b1, 3'd2, 24'd1, 24'd23);
    chk("sll_edge_const", 24'h800000, 0, 0, 0, 0, 1);
    step("srl_big_b", 1'b1, 3'd7, 24'hFFFFFF, 24'h000100);
    chk("srl_oob_const", '0, 0, 1, 1, 0, 0);
    step("srl_23", 1'b1, 3'd7, 24'h800000, 24'd23);
    step("mult_10_5", 1'b1, 3'd3, 24'd10, 24'd5);
`ifdef ALU_MULT_EN
    chk("mult_const", 24'h000032, 0, 0, 1, 0, 0);
    step("mult_ovf", 1'b1, 3'd3, 24'h001000, 24'h001000);
    chk("mult_ovf_const", '0, 1, 1, 0, 0, 0);
`else
    chk("mult_off_const", '0, 0, 1, 1, 0, 0);
`endif
    step("add_vovf", 1'b1, 3'd0, 24'h7FFFFF, 24'd1);
    chk("add_vovf_const", 24'h800000, 0, 0, 1, 1, 1);
    step("add_carry", 1'b1, 3'd0, 24'hFFFFFF, 24'd1);
    chk("add_carry_const", '0, 1, 1, 1, 0, 0);
    step("sub_vovf", 1'b1, 3'd1, 24'h800000, 24'd1);
    step("and", 1'b1, 3'd4, 24'hF0F0F0, 24'hFF00FF);
    step("or", 1'b1, 3'd5, 24'hF0F0F0, 24'h0F0000);
    step("xor", 1'b1, 3'd6, 24'hABCDEF, 24'hABCDEF);
    // Mid-stream reset discards the in-flight result.
    step("mid_rst", 1'b0, 3'd0, 24'd3, 24'd4);
    chk("mid_rst_const", '0, 0, 0, 0, 0, 0);
    step("post_rst", 1'b1, 3'd6, 24'h123456, 24'h00FF00);
    // Random sweep, biasing B toward small shift amounts half the time.
    for (int i = 0; i < 64; i++) begin
      logic [N-1:0] ra, rb;
      ra = N'($urandom);
      rb = ($urandom_range(0, 1) == 0) ? N'($urandom_range(0, 30)) : N'($urandom);
      step("rand", 1'b1, 3'($urandom_range(0, 7)), ra, rb);
    end
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
